vga_timing_checker: RTL

VGA_TIMING_CHECKER -- requirements
Module: vga_timing_checker

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_pulse_meter.sv | 112 +++++++++++
 rtl/vga_timing_checker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA timing checker: default 640x480@60 timing at
// 4 clk per pixel, counter widths and the lock FSM state encoding.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int H_PERIOD_DEF    = 3200;  // 800 px x 4 clk
    localparam int H_PULSE_DEF     = 384;
    localparam int V_LINES_DEF     = 525;
    localparam int V_PULSE_DEF     = 2;
    localparam int LOCK_FRAMES_DEF = 2;

    localparam int HCNT_W = 13;  // clk cycles per line, saturates at 8191
    localparam int VCNT_W = 11;  // lines per frame, saturates at 2047
    localparam int FCNT_W = 16;  // validated frame counter
    localparam int GOOD_W = 8;   // consecutive good frames while acquiring

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vga_pulse_meter.sv
// ----------------------------------------------------------------------------
// vga_pulse_meter
// Edge detector plus period/width meter for one active-low sync signal.
// A single counter restarts on every fall; its value (including the tick of
// the current cycle) is reported as the low width on the rise and as the
// period on the next fall. Counting only advances on cycles with tick_i set,
// so the same block measures clk cycles (tick=1) or lines (tick=hsync fall).
//
// Ports
//   clk_i, rst_ni    clock, synchronous active-low reset
//   sig_i            registered sync sample (active low)
//   tick_i           count enable
//   fall_o           combinational: fall detected this cycle
//   period_stb_o     one-cycle strobe: period captured (registered)
//   period_vld_o     captured period is trustworthy (not first, not saturated)
//   period_o         captured period
//   width_stb_o      one-cycle strobe: low width captured (registered)
//   width_vld_o      captured width is trustworthy
//   width_o          captured low width
// ----------------------------------------------------------------------------
module vga_pulse_meter
    import vga_timing_pkg::*;
#(
    parameter int W = HCNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         sig_i,
    input  logic         tick_i,
    output logic         fall_o,
    output logic         period_stb_o,
    output logic         period_vld_o,
    output logic [W-1:0] period_o,
    output logic         width_stb_o,
    output logic         width_vld_o,
    output logic [W-1:0] width_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         prev_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic         started_q, started_d;
    logic         sat_q, sat_d;
    logic         per_stb_q, per_vld_q;
    logic [W-1:0] per_q;
    logic         wid_stb_q, wid_vld_q;
    logic [W-1:0] wid_q;

    logic         fall, rise;
    logic [W-1:0] meas;
    logic         meas_ok;

    assign fall = prev_q & ~sig_i;
    assign rise = ~prev_q & sig_i;

    // Value of the interval ending this cycle, saturating at CNT_MAX.
    assign meas = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + W'(tick_i);

    // Nothing is trusted until a fall has anchored the counter, and an
    // interval that hit the ceiling is meaningless.
    assign meas_ok = started_q & ~sat_q & (meas != CNT_MAX);

    always_comb begin
        cnt_d     = meas;
        sat_d     = sat_q | (meas == CNT_MAX);
        started_d = started_q | fall;
        if (fall) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            started_q <= 1'b0;
            sat_q     <= 1'b0;
            per_stb_q <= 1'b0;
            per_vld_q <= 1'b0;
            per_q     <= '0;
            wid_stb_q <= 1'b0;
            wid_vld_q <= 1'b0;
            wid_q     <= '0;
        end else begin
            prev_q    <= sig_i;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            sat_q     <= sat_d;
            per_stb_q <= fall & started_q;
            wid_stb_q <= rise & started_q;
            if (fall) begin
                per_q     <= meas;
                per_vld_q <= meas_ok;
            end
            if (rise) begin
                wid_q     <= meas;
                wid_vld_q <= meas_ok;
            end
        end
    end

    assign fall_o       = fall;
    assign period_stb_o = per_stb_q;
    assign period_vld_o = per_vld_q;
    assign period_o     = per_q;
    assign width_stb_o  = wid_stb_q;
    assign width_vld_o  = wid_vld_q;
    assign width_o      = wid_q;

endmodule

// File: rtl/vga_timing_checker.sv
// ----------------------------------------------------------------------------
// vga_timing_checker
// Watches the sync/colour outputs of a VGA controller in the same clock
// domain, measures hsync period/width and vsync period/width (in lines),
// flags deviations, flags colour during blanking, and tracks lock.
//
// Pipeline: input register -> meter capture -> output register, so every
// pulse and capture appears two clk after the edge that first samples a
// new input level.
//
// Ports
//   clk, reset                     clock, synchronous active-low reset
//   vga_hsync, vga_vsync           active-low syncs
//   vga_red, vga_green, vga_blue   colour bits
//   hperiod_meas                   last hsync period (clk cycles)
//   vlines_meas                    last vsync period (lines)
//   h_err, v_err, color_err        one-cycle error pulses
//   err_sticky                     any error since reset
//   locked                         lock FSM is in LOCKED
//   frame_count                    validated frames since reset (wraps)
//
// Lock FSM
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_HUNT    | waiting for first vsync fall, errors only set err_sticky
//   ST_ACQUIRE | counting consecutive clean frames toward LOCK_FRAMES
//   ST_LOCKED  | stable timing; any error falls back to ST_ACQUIRE
// ----------------------------------------------------------------------------
module vga_timing_checker
    import vga_timing_pkg::*;
#(
    parameter int H_PERIOD    = H_PERIOD_DEF,
    parameter int H_PULSE     = H_PULSE_DEF,
    parameter int V_LINES     = V_LINES_DEF,
    parameter int V_PULSE     = V_PULSE_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_hsync,
    input  logic              vga_vsync,
    input  logic              vga_red,
    input  logic              vga_green,
    input  logic              vga_blue,
    output logic [HCNT_W-1:0] hperiod_meas,
    output logic [VCNT_W-1:0] vlines_meas,
    output logic              h_err,
    output logic              v_err,
    output logic              color_err,
    output logic              err_sticky,
    output logic              locked,
    output logic [FCNT_W-1:0] frame_count
);

    localparam logic [HCNT_W-1:0] H_PERIOD_C = HCNT_W'(H_PERIOD);
    localparam logic [HCNT_W-1:0] H_PULSE_C  = HCNT_W'(H_PULSE);
    localparam logic [VCNT_W-1:0] V_LINES_C  = VCNT_W'(V_LINES);
    localparam logic [VCNT_W-1:0] V_PULSE_C  = VCNT_W'(V_PULSE);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_FRAMES);

    // Input sample stage; syncs idle high so reset never fakes an edge.
    logic       hs_q, vs_q;
    logic [2:0] rgb_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else begin
            hs_q  <= vga_hsync;
            vs_q  <= vga_vsync;
            rgb_q <= {vga_red, vga_green, vga_blue};
        end
    end

    logic              h_fall;
    logic              h_per_stb, h_per_vld, h_wid_stb, h_wid_vld;
    logic [HCNT_W-1:0] h_per, h_wid;
    logic              v_fall;
    logic              v_per_stb, v_per_vld, v_wid_stb, v_wid_vld;
    logic [VCNT_W-1:0] v_per, v_wid;

    vga_pulse_meter #(.W(HCNT_W)) u_hmeter (
        .clk_i        (clk),
        .rst_ni       (reset),
        .sig_i        (hs_q),
        .tick_i       (1'b1),
        .fall_o       (h_fall),
        .period_stb_o (h_per_stb),
        .period_vld_o (h_per_vld),
        .period_o     (h_per),
        .width_stb_o  (h_wid_stb),
        .width_vld_o  (h_wid_vld),
        .width_o      (h_wid)
    );

    // Lines are counted on hsync falls; a fall coinciding with the vsync
    // fall belongs to the frame that is ending.
    vga_pulse_meter #(.W(VCNT_W)) u_vmeter (
        .clk_i        (clk),
        .rst_ni       (reset),
        .sig_i        (vs_q),
        .tick_i       (h_fall),
        .fall_o       (v_fall),
        .period_stb_o (v_per_stb),
        .period_vld_o (v_per_vld),
        .period_o     (v_per),
        .width_stb_o  (v_wid_stb),
        .width_vld_o  (v_wid_vld),
        .width_o      (v_wid)
    );

    // Stage-1 events, aligned with the meter capture strobes.
    logic color_s1_q;
    logic vfall_s1_q;
    logic h_err_s1, v_err_s1, err_any;

    always_ff @(posedge clk) begin
        if (!reset) begin
            color_s1_q <= 1'b0;
            vfall_s1_q <= 1'b0;
        end else begin
            color_s1_q <= (|rgb_q) & (~hs_q | ~vs_q);
            vfall_s1_q <= v_fall;
        end
    end

    assign h_err_s1 = (h_per_stb & h_per_vld & (h_per != H_PERIOD_C))
                    | (h_wid_stb & h_wid_vld & (h_wid != H_PULSE_C));
    assign v_err_s1 = (v_per_stb & v_per_vld & (v_per != V_LINES_C))
                    | (v_wid_stb & v_wid_vld & (v_wid != V_PULSE_C));
    assign err_any  = h_err_s1 | v_err_s1 | color_s1_q;

    // Lock FSM
    lock_state_e       state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              dirty_q, dirty_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        dirty_d = dirty_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_HUNT: begin
                if (vfall_s1_q) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                    dirty_d = 1'b0;
                end
            end
            ST_ACQUIRE, ST_LOCKED: begin
                if (err_any) begin
                    // An error coinciding with a vsync fall is charged to
                    // the frame that just ended, so the new frame is clean.
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                    dirty_d = ~vfall_s1_q;
                end else if (vfall_s1_q) begin
                    if (dirty_q) begin
                        dirty_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                        if (state_q == ST_ACQUIRE) begin
                            if ((good_q + 1'b1) >= LOCK_C) begin
                                state_d = ST_LOCKED;
                                good_d  = '0;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Output stage
    logic [HCNT_W-1:0] hperiod_q;
    logic [VCNT_W-1:0] vlines_q;
    logic              h_err_q, v_err_q, color_err_q, sticky_q, locked_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            good_q      <= '0;
            dirty_q     <= 1'b0;
            fcnt_q      <= '0;
            hperiod_q   <= '0;
            vlines_q    <= '0;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
            color_err_q <= 1'b0;
            sticky_q    <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            dirty_q     <= dirty_d;
            fcnt_q      <= fcnt_d;
            h_err_q     <= h_err_s1;
            v_err_q     <= v_err_s1;
            color_err_q <= color_s1_q;
            sticky_q    <= sticky_q | err_any;
            locked_q    <= (state_d == ST_LOCKED);
            if (h_per_stb) hperiod_q <= h_per;
            if (v_per_stb) vlines_q  <= v_per;
        end
    end

    assign hperiod_meas = hperiod_q;
    assign vlines_meas  = vlines_q;
    assign h_err        = h_err_q;
    assign v_err        = v_err_q;
    assign color_err    = color_err_q;
    assign err_sticky   = sticky_q;
    assign locked       = locked_q;
    assign frame_count  = fcnt_q;

endmodule
